// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the seven-segment display block
// Holds the display mode encodings and the active-low segment patterns
// (bit7=a .. bit1=g, bit0=dp; dp is never lit).
package seg_pkg;

  typedef enum logic [1:0] {
    MODE_HEX       = 2'b00,
    MODE_BIT       = 2'b01,
    MODE_BLANK     = 2'b10,
    MODE_BLANK_ALT = 2'b11
  } seg_mode_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'h03;
  localparam logic [7:0] SEG_ONE   = 8'h9F;

  // Element 15 first: SEG_HEX[n] is the pattern for nibble value n.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h71, 8'h61, 8'h85, 8'h63,   // F E d C
    8'hC1, 8'h11, 8'h09, 8'h01,   // b A 9 8
    8'h1F, 8'h41, 8'h49, 8'h99,   // 7 6 5 4
    8'h0D, 8'h25, 8'h9F, 8'h03    // 3 2 1 0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to seven-segment pattern decoder
// Ports:
//   nib : 4-bit value to display
//   pat : active-low segment pattern (a..g, dp) for that value
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] pat
);

  assign pat = SEG_HEX[nib];

endmodule

// File: rtl/seg_disp.sv
// rtl/seg_disp.sv - multi-digit seven-segment driver with blink, zero suppression and scan
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture data/mode/digit_en/blink/lz_en into shadow registers
//   data        : nibble i feeds digit i (bit i in bit mode)
//   mode        : 00 hex, 01 bit, 1x blank
//   digit_en    : per-digit enable (0 blanks)
//   blink       : per-digit blink select
//   lz_en       : leading-zero suppression in hex mode
//   seg         : registered static patterns, byte i = digit i, active-low
//   an          : scanned anode select, active-low one-hot
//   seg_scan    : pattern of the digit currently selected by an
module seg_disp
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 4,
  parameter int SCAN_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [1:0]              mode,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_en,
  output logic [8*NUM_DIGITS-1:0] seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg_scan
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [LW-1:0] SLOT_LAST  = LW'(NUM_DIGITS - 1);

  // Shadow registers
  logic [4*NUM_DIGITS-1:0] data_q;
  seg_mode_e               mode_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    lz_q;

  // Free-running counters
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [SW-1:0] scan_cnt;
  logic [LW-1:0] slot;

  logic [8*NUM_DIGITS-1:0] seg_q;
  logic [8*NUM_DIGITS-1:0] seg_d;
  logic [7:0]              hex_pat [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   upper_nz;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_hex_decode u_dec (
      .nib (data_q[4*g +: 4]),
      .pat (hex_pat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      mode_q      <= MODE_HEX;
      en_q        <= '0;
      blink_q     <= '0;
      lz_q        <= 1'b0;
      seg_q       <= '1;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      scan_cnt    <= '0;
      slot        <= '0;
    end else begin
      if (load) begin
        data_q  <= data;
        mode_q  <= seg_mode_e'(mode);
        en_q    <= digit_en;
        blink_q <= blink;
        lz_q    <= lz_en;
      end

      seg_q <= seg_d;

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        slot     <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // upper_nz[i] is set when nibble i or any nibble above it is nonzero;
  // a digit with upper_nz clear is a leading zero.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    upper_nz = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc         = acc | (data_q[4*i +: 4] != 4'h0);
      upper_nz[i] = acc;
    end
  end

  // Blanking priority: mode blank, digit disable, blink phase, leading zero.
  always_comb begin
    seg_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (mode_q != MODE_HEX && mode_q != MODE_BIT) begin
        seg_d[8*i +: 8] = SEG_BLANK;
      end else if (!en_q[i]) begin
        seg_d[8*i +: 8] = SEG_BLANK;
      end else if (blink_phase && blink_q[i]) begin
        seg_d[8*i +: 8] = SEG_BLANK;
      end else if (mode_q == MODE_BIT) begin
        seg_d[8*i +: 8] = data_q[i] ? SEG_ONE : SEG_ZERO;
      end else if (lz_q && (i != 0) && !upper_nz[i]) begin
        seg_d[8*i +: 8] = SEG_BLANK;
      end else begin
        seg_d[8*i +: 8] = hex_pat[i];
      end
    end
  end

  assign seg      = seg_q;
  assign an       = ~(NUM_DIGITS'(1) << slot);
  assign seg_scan = 8'(seg_q >> {slot, 3'b000});

endmodule

// File: tb/tb_seg_disp.sv
// tb/tb_seg_disp.sv - self-checking bench for seg_disp with a behavioural display model
module tb_seg_disp;

  localparam int N  = 8;
  localparam int BD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  blink = '0;
  logic        lz_en = 1'b0;
  logic [63:0] seg;
  logic [7:0]  an;
  logic [7:0]  seg_scan;

  always #5 clk = ~clk;

  seg_disp #(.NUM_DIGITS(N), .BLINK_DIV(BD), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .mode     (mode),
    .digit_en (digit_en),
    .blink    (blink),
    .lz_en    (lz_en),
    .seg      (seg),
    .an       (an),
    .seg_scan (seg_scan)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  logic [31:0] m_data;
  logic [1:0]  m_mode;
  logic [7:0]  m_en;
  logic [7:0]  m_bl;
  logic        m_lz;
  int          m_k;
  logic [63:0] exp_seg;
  bit          m_valid = 1'b0;

  function automatic logic [63:0] disp(input logic [31:0] d, input logic [1:0] m,
                                       input logic [7:0] en, input logic [7:0] bl,
                                       input logic lz, input int ph);
    logic [63:0] r;
    int h;
    h = -1;
    for (int i = 0; i < N; i++) if (d[4*i +: 4] != 4'h0) h = i;
    for (int i = 0; i < N; i++) begin
      if (m >= 2'd2)                           r[8*i +: 8] = 8'hFF;
      else if (!en[i])                         r[8*i +: 8] = 8'hFF;
      else if (ph == 1 && bl[i])               r[8*i +: 8] = 8'hFF;
      else if (m == 2'd1)                      r[8*i +: 8] = d[i] ? 8'h9F : 8'h03;
      else if (lz && i > h && i > 0)           r[8*i +: 8] = 8'hFF;
      else                                     r[8*i +: 8] = hex_tab[d[4*i +: 4]];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_data  = '0;
      m_mode  = '0;
      m_en    = '0;
      m_bl    = '0;
      m_lz    = 1'b0;
      m_k     = 0;
      exp_seg = '1;
      m_valid = 1'b1;
    end else begin
      exp_seg = disp(m_data, m_mode, m_en, m_bl, m_lz, (m_k / BD) % 2);
      if (load) begin
        m_data = data;
        m_mode = mode;
        m_en   = digit_en;
        m_bl   = blink;
        m_lz   = lz_en;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int slot;
      logic [7:0] e_an;
      logic [63:0] sh;
      slot = (m_k / SD) % N;
      e_an = ~(8'h01 << slot);
      sh   = exp_seg >> (8 * slot);
      chk("seg", seg, exp_seg);
      chk("an", {56'h0, an}, {56'h0, e_an});
      chk("seg_scan", {56'h0, seg_scan}, {56'h0, sh[7:0]});
    end
  end

  task automatic do_load(input logic [31:0] d, input logic [1:0] m, input logic [7:0] en,
                         input logic [7:0] bl, input logic lz);
    @(posedge clk);
    #1;
    load = 1'b1; data = d; mode = m; digit_en = en; blink = bl; lz_en = lz;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int ff_cnt;
    int other_ff;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_seg", seg, '1);
    chk("rst_an", {56'h0, an}, 64'hFE);
    chk("rst_scan", {56'h0, seg_scan}, 64'hFF);

    do_load(32'h0123ABCD, 2'b00, 8'hFF, 8'h00, 1'b0);
    chk("hex_lit", seg, 64'h039F250D11C16385);
    chk("hex_model", exp_seg, 64'h039F250D11C16385);

    do_load(32'h000000A5, 2'b00, 8'hFF, 8'h00, 1'b1);
    chk("lz_lit", seg, 64'hFFFFFFFFFFFF1149);
    chk("lz_model", exp_seg, 64'hFFFFFFFFFFFF1149);

    do_load(32'h00000000, 2'b00, 8'hFF, 8'h00, 1'b1);
    chk("lz_zero_lit", seg, 64'hFFFFFFFFFFFFFF03);

    do_load(32'h000000A5, 2'b01, 8'hFF, 8'h00, 1'b1);
    chk("bit_lit", seg, 64'h9F039F03039F039F);
    chk("bit_model", exp_seg, 64'h9F039F03039F039F);

    do_load(32'h0123ABCD, 2'b10, 8'hFF, 8'h00, 1'b0);
    chk("blank_lit", seg, '1);

    do_load(32'h0123ABCD, 2'b00, 8'h0F, 8'h00, 1'b0);
    chk("en_lit", seg, 64'hFFFFFFFF11C16385);

    do_load(32'h0123ABCD, 2'b00, 8'hFF, 8'h01, 1'b0);
    ff_cnt   = 0;
    other_ff = 0;
    for (int c = 0; c < 16; c++) begin
      if (seg[7:0] == 8'hFF) ff_cnt++;
      if (seg[15:8] == 8'hFF) other_ff++;
      @(negedge clk);
    end
    chk("blink_ff_cycles", 64'(ff_cnt), 64'd8);
    chk("blink_steady", 64'(other_ff), 64'd0);

    // Back-to-back loads: the second one must win.
    @(posedge clk);
    #1 load = 1'b1; data = 32'h11111111; mode = 2'b00; digit_en = 8'hFF; blink = 8'h00; lz_en = 1'b0;
    @(posedge clk);
    #1 data = 32'h89ABCDEF;
    @(posedge clk);
    #1 load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_lit", seg, 64'h010911C163856171);

    // Reset overrides a simultaneous load.
    @(posedge clk);
    #1 rst = 1'b1; load = 1'b1; data = 32'h12345678;
    @(posedge clk);
    #1 rst = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("rstld_seg", seg, '1);
    chk("rstld_an", {56'h0, an}, 64'hFE);
    chk("rstld_scan", {56'h0, seg_scan}, 64'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstld_noload", seg, '1);

    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rst      = ($urandom % 64) == 0;
      load     = ($urandom % 3) == 0;
      data     = $urandom >> ($urandom % 32);
      mode     = (($urandom % 5) == 0) ? 2'($urandom) : 2'($urandom % 2);
      digit_en = (($urandom % 4) == 0) ? 8'($urandom) : 8'hFF;
      blink    = 8'($urandom);
      lz_en    = 1'($urandom);
    end
    @(posedge clk);
    #1 rst = 1'b0; load = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seg_disp.md
SEG_DISP -- requirements
Module: seg_disp

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of digits driven (1..8).
REQ-002 Parameter BLINK_DIV, default 4: cycles per blink phase (>=2).
REQ-003 Parameter SCAN_DIV, default 2: cycles per scanned digit slot (>=1).
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port load, input, 1: capture data/mode/digit_en/blink/lz_en this cycle.
REQ-007 Port data, input, 4*NUM_DIGITS: nibble i feeds digit i.
REQ-008 Port mode, input, 2: 00 hex, 01 bit (digit i shows data[i] as 0/1), 10 blank, 11 blank.
REQ-009 Port digit_en, input, NUM_DIGITS: per-digit enable; 0 blanks the digit.
REQ-010 Port blink, input, NUM_DIGITS: per-digit blink select.
REQ-011 Port lz_en, input, 1: leading-zero suppression, hex mode only.
REQ-012 Port seg, output, 8*NUM_DIGITS: static active-low patterns, byte i = digit i; bit7=a .. bit1=g, bit0=dp.
REQ-013 Port an, output, NUM_DIGITS: scanned anode select, active-low one-hot.
REQ-014 Port seg_scan, output, 8: pattern of the digit selected by an.

Function
REQ-015 Shadow registers SHALL hold data, mode, digit_en, blink, lz_en; updated only when load=1.
REQ-016 seg SHALL be registered; load at edge t SHALL show new contents from edge t+1 (one-cycle latency).
REQ-017 Hex patterns SHALL be 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 b:C1 C:63 d:85 E:61 F:71 (hex bytes).
REQ-018 Bit mode SHALL show 03 for a 0 and 9F for a 1, from data bit i (not nibble i).
REQ-019 Blank pattern SHALL be FF; dp is never lit.
REQ-020 With lz_en=1 in hex mode, zero nibbles above the highest nonzero nibble SHALL show FF; digit 0 always displays.
REQ-021 Blink counter SHALL count 0..BLINK_DIV-1 and wrap, toggling blink_phase at each wrap; in phase 1, digits with blink=1 SHALL show FF.
REQ-022 Blanking priority: mode blank > digit_en=0 > blink phase > leading-zero > decoded pattern.
REQ-023 Scan counter SHALL advance the slot index every SCAN_DIV cycles, wrapping NUM_DIGITS-1 -> 0.
REQ-024 an SHALL assert (0) only bit slot; seg_scan SHALL equal byte slot of seg, same cycle alignment.
REQ-025 load SHALL NOT reset blink or scan counters; counters run continuously.
REQ-026 load on consecutive cycles SHALL each take effect; last one wins.

Reset
REQ-027 On rst=1 at an edge: shadows cleared (mode=00, digit_en=0, blink=0, lz_en=0, data=0).
REQ-028 On reset: seg all FF, an all 1 except bit 0 = 0, seg_scan FF, counters 0, blink_phase 0.
REQ-029 rst SHALL override a simultaneous load; reset mid-scan or mid-blink restarts from slot 0, phase 0.

Structure
REQ-030 Package seg_pkg SHALL hold the 16 hex pattern constants, SEG_BLANK, SEG_ZERO, SEG_ONE and mode encodings.
REQ-031 Sub-module seg_hex_decode (4-bit in, 8-bit pattern out, combinational) SHALL be instantiated per digit.

Verification
REQ-032 Reset then idle -> seg = all FF, an = FE (N=8), seg_scan = FF.
REQ-033 load, mode=00, data=32'h0123ABCD, digit_en=FF -> next cycle seg bytes 7..0 = 03 9F 25 0D 11 C1 63 85.
REQ-034 Same data 32'h000000A5, lz_en=1 -> bytes 7..2 = FF, byte1 = 11, byte0 = 49; data 0 -> only byte0 = 03.
REQ-035 mode=01, data[7:0]=8'b10100101 -> bytes 7..0 = 9F 03 9F 03 03 9F 03 9F.
REQ-036 blink=01, BLINK_DIV=4 -> byte0 alternates pattern/FF every 4 cycles; other bytes steady.
REQ-037 SCAN_DIV=2 -> an steps FE, FD, FB ... 7F, FE every 2 cycles; seg_scan tracks selected byte; rst with load high -> reset values win.
